// File: rtl/lfsr_stream_if.sv
// Stream/control bundle between an LFSR word generator and its consumer.
// The master drives seeding, enable and ready; the slave (generator) returns words and status.
interface lfsr_stream_if #(
  parameter int unsigned WIDTH = 64
);
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             enable;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             lockup;

  modport master (
    output seed_load,
    output seed,
    output enable,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  lockup
  );

  modport slave (
    input  seed_load,
    input  seed,
    input  enable,
    input  out_ready,
    output out_valid,
    output out_data,
    output lockup
  );
endinterface

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR word generator with a valid/ready output stream and all-zero lockup flag.
// Optional: define LFSR_LOCKUP_RECOVER_EN to restart a zero state at all-ones on the next advance.
module lfsr_stream #(
  parameter int unsigned      WIDTH = 64,
  parameter logic [WIDTH-1:0] TAPS  = 64'hD800_0000_0000_0000,
  parameter int unsigned      STEPS = 1
) (
  input logic              clk,
  input logic              rst_n,
  lfsr_stream_if.slave     strm_io
);

`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam bit RecoverEn = 1'b1;
`else
  localparam bit RecoverEn = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;
  logic             transfer;
  logic             adv_en;

  // STEPS single shifts unrolled into one combinational advance.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int unsigned i = 0; i < STEPS; i++) begin
      t = {t[WIDTH-2:0], ^(t & TAPS)};
    end
    return t;
  endfunction

  assign transfer = valid_q & strm_io.out_ready;
  assign adv_en   = strm_io.enable & (transfer | ~valid_q);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (strm_io.seed_load) begin
      state_d = StRun;
      data_d  = strm_io.seed;
      valid_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          valid_d = 1'b0;
        end
        StRun: begin
          if (adv_en) begin
            valid_d = 1'b1;
            if (RecoverEn && (data_q == '0)) begin
              data_d = '1;
            end else begin
              data_d = advance(data_q);
            end
          end else if (transfer) begin
            // Word taken with generation paused: drop valid, keep the state.
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
    lock_d = (state_d == StRun) && (data_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
    end
  end

  assign strm_io.out_data  = data_q;
  assign strm_io.out_valid = valid_q;
  assign strm_io.lockup    = lock_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: directed vector table, hand sequences and a random run against a model.
module tb_lfsr_stream;

`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam bit RecoverEn = 1'b1;
`else
  localparam bit RecoverEn = 1'b0;
`endif

  localparam logic [127:0] Taps64 = 128'hD800_0000_0000_0000;
  localparam logic [127:0] Taps4  = 128'hC;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lfsr_stream_if #(.WIDTH(64)) if_a ();
  lfsr_stream_if #(.WIDTH(64)) if_b ();
  lfsr_stream_if #(.WIDTH(4))  if_c ();

  // if_b mirrors the stimulus of if_a, only STEPS differs.
  assign if_b.seed_load = if_a.seed_load;
  assign if_b.seed      = if_a.seed;
  assign if_b.enable    = if_a.enable;
  assign if_b.out_ready = if_a.out_ready;

  lfsr_stream u_dut_a (.clk(clk), .rst_n(rst_n), .strm_io(if_a));
  lfsr_stream #(.WIDTH(64), .TAPS(64'hD800_0000_0000_0000), .STEPS(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .strm_io(if_b));
  lfsr_stream #(.WIDTH(4), .TAPS(4'b1100), .STEPS(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .strm_io(if_c));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: n single Fibonacci shifts of a w-bit register.
  function automatic logic [127:0] ref_step(input logic [127:0] s, input int w,
                                            input logic [127:0] taps, input int n);
    logic [127:0] mask;
    logic [127:0] r;
    mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
    r = s & mask;
    for (int k = 0; k < n; k++) r = ((r << 1) | {127'd0, ^(r & taps)}) & mask;
    return r;
  endfunction

  typedef struct {
    bit           run;
    bit           valid;
    logic [127:0] data;
    bit           lock;
  } mdl_t;

  function automatic mdl_t mdl_next(input mdl_t m, input bit rst, input bit ld,
                                    input logic [127:0] sd, input bit en, input bit rdy,
                                    input int steps);
    mdl_t n;
    n = m;
    if (!rst) begin
      n.run = 0; n.valid = 0; n.data = '0;
    end else if (ld) begin
      n.run = 1; n.valid = 1; n.data = sd;
    end else if (m.run) begin
      if (en && (!m.valid || rdy)) begin
        n.valid = 1;
        n.data  = (RecoverEn && m.data == 0) ? 128'hFFFF_FFFF_FFFF_FFFF
                                             : ref_step(m.data, 64, Taps64, steps);
      end else if (m.valid && rdy) begin
        n.valid = 0;
      end
    end
    n.lock = n.run && (n.data == 0);
    return n;
  endfunction

  typedef struct {
    bit          rst_n;
    bit          ld;
    logic [63:0] seed;
    bit          en;
    bit          rdy;
    bit          exp_valid;
    logic [63:0] exp_data;
    logic [63:0] exp_s4;
    bit          exp_lock;
  } vec_t;

  vec_t vecs[13];

  task automatic drive_a(input bit r, input bit ld, input logic [63:0] sd,
                         input bit en, input bit rdy);
    rst_n          = r;
    if_a.seed_load = ld;
    if_a.seed      = sd;
    if_a.enable    = en;
    if_a.out_ready = rdy;
  endtask

  initial begin
    logic [63:0] ones;
    logic [63:0] sd;
    logic [3:0]  words[16];
    bit          seen[16];
    int          distinct;
    mdl_t        ma, mb;

    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    drive_a(1'b0, 1'b0, '0, 1'b0, 1'b0);
    if_c.seed_load = 1'b0;
    if_c.seed      = '0;
    if_c.enable    = 1'b1;
    if_c.out_ready = 1'b1;

    //           rst ld seed  en rdy  valid data                   s4 data                 lock
    vecs[0]  = '{0, 0, 64'h0, 1, 1, 0, 64'h0,                  64'h0,                  0};
    vecs[1]  = '{1, 0, 64'h0, 1, 1, 0, 64'h0,                  64'h0,                  0};
    vecs[2]  = '{1, 1, ones,  0, 0, 1, ones,                   ones,                   0};
    vecs[3]  = '{1, 0, 64'h0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF0, 0};
    vecs[4]  = '{1, 0, 64'h0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FF00, 0};
    vecs[5]  = '{1, 0, 64'h0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FF00, 0};
    vecs[6]  = '{1, 0, 64'h0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FF00, 0};
    vecs[7]  = '{1, 0, 64'h0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FF00, 0};
    vecs[8]  = '{1, 0, 64'h0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_F000, 0};
    vecs[9]  = '{1, 1, 64'h0, 1, 1, 1, 64'h0,                  64'h0,                  1};
    if (RecoverEn) vecs[10] = '{1, 0, 64'h0, 1, 1, 1, ones,   ones,                   0};
    else           vecs[10] = '{1, 0, 64'h0, 1, 1, 1, 64'h0,  64'h0,                  1};
    vecs[11] = '{0, 1, 64'h5, 1, 0, 0, 64'h0,                  64'h0,                  0};
    vecs[12] = '{1, 0, 64'h0, 1, 1, 0, 64'h0,                  64'h0,                  0};

    for (int i = 0; i < 13; i++) begin
      drive_a(vecs[i].rst_n, vecs[i].ld, vecs[i].seed, vecs[i].en, vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d valid", i), {127'd0, if_a.out_valid}, {127'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d data", i), {64'd0, if_a.out_data}, {64'd0, vecs[i].exp_data});
      chk($sformatf("vec%0d lockup", i), {127'd0, if_a.lockup}, {127'd0, vecs[i].exp_lock});
      chk($sformatf("vec%0d s4 data", i), {64'd0, if_b.out_data}, {64'd0, vecs[i].exp_s4});
    end

    // Backpressure: seed held stable for five cycles, then one word per cycle.
    sd = 64'h0123_4567_89AB_CDEF;
    drive_a(1'b1, 1'b1, sd, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      if_a.seed_load = 1'b0;
      chk($sformatf("stall%0d data", k), {64'd0, if_a.out_data}, {64'd0, sd});
      chk($sformatf("stall%0d valid", k), {127'd0, if_a.out_valid}, 128'd1);
    end
    if_a.out_ready = 1'b1;
    tick();
    chk("stall release data", {64'd0, if_a.out_data}, ref_step({64'd0, sd}, 64, Taps64, 1));
    chk("stall release valid", {127'd0, if_a.out_valid}, 128'd1);

    // Zero seed: stuck at zero, or recovers to all-ones when the option is built in.
    drive_a(1'b1, 1'b1, 64'h0, 1'b1, 1'b1);
    tick();
    if_a.seed_load = 1'b0;
    chk("zero seed data", {64'd0, if_a.out_data}, 128'd0);
    chk("zero seed lockup", {127'd0, if_a.lockup}, 128'd1);
    if (RecoverEn) begin
      tick();
      chk("recover data", {64'd0, if_a.out_data}, {64'd0, ones});
      chk("recover lockup", {127'd0, if_a.lockup}, 128'd0);
    end else begin
      for (int k = 0; k < 10; k++) begin
        tick();
        chk($sformatf("stuck%0d data", k), {64'd0, if_a.out_data}, 128'd0);
        chk($sformatf("stuck%0d lockup", k), {127'd0, if_a.lockup}, 128'd1);
      end
    end

    // 4-bit maximal sequence: 15 distinct non-zero words, then back to the seed.
    if_c.seed_load = 1'b1;
    if_c.seed      = 4'h1;
    tick();
    if_c.seed_load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      words[k] = if_c.out_data;
      if (k < 15)
        chk($sformatf("w4 word%0d", k), {124'd0, words[k]}, ref_step(128'd1, 4, Taps4, k));
    end
    for (int k = 0; k < 16; k++) seen[k] = 0;
    distinct = 0;
    for (int k = 0; k < 15; k++) begin
      if (words[k] != 4'h0 && !seen[words[k]]) distinct++;
      seen[words[k]] = 1;
    end
    chk("w4 distinct nonzero", distinct, 15);
    chk("w4 word15", {124'd0, words[15]}, 128'd1);

    // Random run against the model, starting from a reset cycle.
    ma = '{run: 0, valid: 0, data: '0, lock: 0};
    mb = ma;
    for (int i = 0; i < 400; i++) begin
      bit          r, ld, en, rdy;
      logic [63:0] s;
      r   = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      ld  = ($urandom_range(0, 15) == 0);
      s   = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
      en  = ($urandom_range(0, 3) != 0);
      rdy = $urandom_range(0, 1);
      drive_a(r, ld, s, en, rdy);
      ma = mdl_next(ma, r, ld, {64'd0, s}, en, rdy, 1);
      mb = mdl_next(mb, r, ld, {64'd0, s}, en, rdy, 4);
      tick();
      chk($sformatf("rnd%0d valid", i), {127'd0, if_a.out_valid}, {127'd0, ma.valid});
      chk($sformatf("rnd%0d data", i), {64'd0, if_a.out_data}, ma.data);
      chk($sformatf("rnd%0d lockup", i), {127'd0, if_a.lockup}, {127'd0, ma.lock});
      chk($sformatf("rnd%0d s4 valid", i), {127'd0, if_b.out_valid}, {127'd0, mb.valid});
      chk($sformatf("rnd%0d s4 data", i), {64'd0, if_b.out_data}, mb.data);
      chk($sformatf("rnd%0d s4 lockup", i), {127'd0, if_b.lockup}, {127'd0, mb.lock});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
